bcd_count_digits: RTL and testbench
===================================

# bcd_count_digits

Four-digit BCD up/down counter with built-in prescaler and seven-segment encoding, sitting directly upstream of the 4-digit scan driver. It advances once every TICK_DIV enabled clocks, wraps between 0000 and MAX_COUNT, and presents one registered active-low segment pattern per digit on seg_data_0..seg_data_3 for the scanner to multiplex.

## Interface
Parameters:
- TICK_DIV, 50_000_000, clocks per count step; legal range 2..2^26; the prescaler counter is 26 bits wide.
- MAX_COUNT, 16'h9675, terminal value in packed BCD; every nibble must be ≤ 9.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  1 = prescaler runs; 0 = prescaler and count hold.
- up_down  input  1  1 = count up, 0 = count down; sampled on the step edge.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  16  packed BCD value to load; [15:12] is thousands.
- count_bcd  output  16  current count in packed BCD, registered.
- wrap  output  1  one-cycle pulse on a wrap step.
- seg_data_0  output  7  thousands digit pattern, leftmost digit.
- seg_data_1  output  7  hundreds digit pattern.
- seg_data_2  output  7  tens digit pattern.
- seg_data_3  output  7  units digit pattern.

## Operation
- Segment encoding is active-low, bit order {g,f,e,d,c,b,a} with bit0 = a.
  - Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A nibble greater than 9 is unreachable; if decoded, it gives 1111111 (blank).
- Prescaler counts 0..TICK_DIV-1 while en=1. A step occurs on the edge where prescaler = TICK_DIV-1 and en=1; the prescaler returns to 0 on that edge.
- Priority per edge: clear > load > step.
- clear:
  - count_bcd ← 0000 and prescaler ← 0.
  - No wrap pulse.
  - Takes effect regardless of en.
- load:
  - Load is valid when every nibble of load_val is ≤ 9 and load_val ≤ MAX_COUNT, compared as BCD (numerically, digit by digit).
  - Valid load: count_bcd ← load_val and prescaler ← 0.
  - Invalid load: ignored entirely. Count and prescaler are unchanged and the step that edge is suppressed.
  - Takes effect regardless of en.
- Step up:
  - If count = MAX_COUNT, count ← 0000 and wrap = 1.
  - Otherwise BCD increment: the units digit wraps 9→0 with a carry into the next digit, and so on up the digits.
- Step down:
  - If count = 0000, count ← MAX_COUNT and wrap = 1.
  - Otherwise BCD decrement: a digit wraps 0→9 with a borrow from the next digit.
- Once any edge has acted, count_bcd never holds a value above MAX_COUNT or a non-BCD nibble.
- Reset (rst_n=0, asynchronous):
  - Prescaler = 0, count_bcd = 0000, wrap = 0.
  - seg_data_0..3 = 1000000 (all digits show 0).
  - Outputs hold these values until the first rising edge after rst_n deasserts.
  - Reset asserted mid-step or mid-load aborts that operation with no partial update.

## Timing
- count_bcd and wrap update on the same edge as the step, load, or clear that causes the change.
- seg_data_0..3 are a registered decode of count_bcd: each lags count_bcd by exactly 1 clock.
- The wrap pulse is exactly 1 clock wide. It is high in the cycle after the wrap edge, alongside the new count_bcd.
- Step period is TICK_DIV clocks while en stays high.
  - Dropping en freezes the prescaler value.
  - Raising en again resumes from the frozen value; the count does not restart.
- clear or load on the same edge as a pending step: the step is discarded and the prescaler restarts from 0.
- Changing up_down between steps has no effect until the next step edge.

## Test plan
(Run with TICK_DIV=4, MAX_COUNT=16'h9675.)
- Reset then en=1, up_down=1, 12 clocks:
  - count_bcd steps 0000→0001→0002→0003 at clocks 4, 8 and 12.
  - seg_data_3 goes 1000000→1111001→0100100→0110000, each change 1 clock after the count changes.
- Load 16'h0099, then one up step:
  - count_bcd = 16'h0100.
  - seg_data_1 = 1111001, seg_data_2 = 1000000, seg_data_3 = 1000000.
- Load 16'h9675, then one up step:
  - count_bcd = 0000 and wrap = 1 for 1 clock.
  - Then switch to up_down=0: the next step gives count_bcd = 9675 with wrap = 1 again.
- Invalid loads, tried separately: load_val = 16'h9676, then 16'h00A0.
  - count_bcd unchanged in both cases.
  - No step occurs on the load edge.
- Assert clear and load (16'h1234) on the same edge as a pending step:
  - count_bcd = 0000 and the prescaler restarts, giving the next step 4 clocks later.
  - Separately, en=0 for 10 clocks: count and prescaler hold.
- Assert rst_n=0 asynchronously mid-count at 16'h4321:
  - count_bcd = 0000, seg_data_0..3 = 1000000 and wrap = 0 before the next clock edge.

Source files
------------

// File: rtl/bcd_count_digits_if.sv
// Control inputs and count/segment outputs of the BCD digit counter.
interface bcd_count_digits_if;
  logic        en;
  logic        up_down;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [6:0]  seg_data_0;
  logic [6:0]  seg_data_1;
  logic [6:0]  seg_data_2;
  logic [6:0]  seg_data_3;

  modport master (
    output en, up_down, clear, load, load_val,
    input  count_bcd, wrap, seg_data_0, seg_data_1, seg_data_2, seg_data_3
  );

  modport slave (
    input  en, up_down, clear, load, load_val,
    output count_bcd, wrap, seg_data_0, seg_data_1, seg_data_2, seg_data_3
  );
endinterface

// File: rtl/bcd_count_digits.sv
// Four-digit packed-BCD up/down counter with prescaler, wrap pulse and a
// registered active-low seven-segment decode per digit ({g,f,e,d,c,b,a}).
module bcd_count_digits #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [15:0] MAX_COUNT = 16'h9675
) (
  input logic               clk,
  input logic               rst_n,
  bcd_count_digits_if.slave bus
);

  localparam logic [25:0] PRESC_LAST = 26'(TICK_DIV - 1);
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

  logic [25:0]     presc_q;
  logic [15:0]     count_q;
  logic            wrap_q;
  logic [3:0][6:0] seg_q;

  logic            step;
  logic            load_ok;
  logic            at_wrap;
  logic [15:0]     step_val;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // With every nibble <= 9, packed BCD orders the same as plain binary.
  always_comb begin
    step     = bus.en && (presc_q == PRESC_LAST);
    load_ok  = bcd_valid(bus.load_val) && (bus.load_val <= MAX_COUNT);
    at_wrap  = bus.up_down ? (count_q == MAX_COUNT) : (count_q == '0);
    step_val = '0;
    if (bus.up_down) begin
      step_val = at_wrap ? '0 : bcd_inc(count_q);
    end else begin
      step_val = at_wrap ? MAX_COUNT : bcd_dec(count_q);
    end
  end

  // An invalid load still blocks the step and freezes the prescaler that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.clear) begin
        presc_q <= '0;
        count_q <= '0;
      end else if (bus.load) begin
        if (load_ok) begin
          presc_q <= '0;
          count_q <= bus.load_val;
        end
      end else if (step) begin
        presc_q <= '0;
        count_q <= step_val;
        wrap_q  <= at_wrap;
      end else if (bus.en) begin
        presc_q <= presc_q + 26'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {4{SEG_ZERO}};
    end else begin
      seg_q[0] <= seg_decode(count_q[15:12]);
      seg_q[1] <= seg_decode(count_q[11:8]);
      seg_q[2] <= seg_decode(count_q[7:4]);
      seg_q[3] <= seg_decode(count_q[3:0]);
    end
  end

  assign bus.count_bcd  = count_q;
  assign bus.wrap       = wrap_q;
  assign bus.seg_data_0 = seg_q[0];
  assign bus.seg_data_1 = seg_q[1];
  assign bus.seg_data_2 = seg_q[2];
  assign bus.seg_data_3 = seg_q[3];

endmodule

// File: tb/tb_bcd_count_digits.sv
// Scoreboard bench for bcd_count_digits: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_bcd_count_digits;

  localparam int F_CNT  = 0;
  localparam int F_WRAP = 1;
  localparam int F_SEG0 = 2;
  localparam int F_SEG1 = 3;
  localparam int F_SEG2 = 4;
  localparam int F_SEG3 = 5;

  localparam logic [15:0] S0 = 16'(7'b1000000);
  localparam logic [15:0] S1 = 16'(7'b1111001);
  localparam logic [15:0] S2 = 16'(7'b0100100);
  localparam logic [15:0] S3 = 16'(7'b0110000);
  localparam logic [15:0] S4 = 16'(7'b0011001);
  localparam logic [15:0] S9 = 16'(7'b0010000);

  typedef struct {
    int          cyc;
    int          fld;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  bcd_count_digits_if bus ();

  bcd_count_digits #(
    .TICK_DIV (4),
    .MAX_COUNT(16'h9675)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] actual(input int fld);
    case (fld)
      F_CNT:   return bus.count_bcd;
      F_WRAP:  return 16'(bus.wrap);
      F_SEG0:  return 16'(bus.seg_data_0);
      F_SEG1:  return 16'(bus.seg_data_1);
      F_SEG2:  return 16'(bus.seg_data_2);
      F_SEG3:  return 16'(bus.seg_data_3);
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic string fname(input int fld);
    case (fld)
      F_CNT:   return "count_bcd";
      F_WRAP:  return "wrap";
      F_SEG0:  return "seg_data_0";
      F_SEG1:  return "seg_data_1";
      F_SEG2:  return "seg_data_2";
      F_SEG3:  return "seg_data_3";
      default: return "unknown";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.fld);
      checks = checks + 1;
      if (e.cyc != cyc || a !== e.val) begin
        errors = errors + 1;
        $display("FAIL %s @cycle %0d (sampled %0d): got %h expected %h",
                 fname(e.fld), e.cyc, cyc, a, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ex(input int c, input int f, input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  int c0, l, n, k, m;

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_down  = 1'b1;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    ticks(2);

    // reset values, still held after release until the next edge
    c0 = cyc;
    ex(c0, F_CNT, 16'h0000);
    ex(c0, F_WRAP, 16'h0);
    ex(c0, F_SEG0, S0);
    ex(c0, F_SEG1, S0);
    ex(c0, F_SEG2, S0);
    ex(c0, F_SEG3, S0);
    rst_n   = 1'b1;
    bus.en  = 1'b1;

    // count up every 4 clocks, segment lags by one
    ex(c0 + 3,  F_CNT,  16'h0000);
    ex(c0 + 4,  F_CNT,  16'h0001);
    ex(c0 + 4,  F_SEG3, S0);
    ex(c0 + 4,  F_WRAP, 16'h0);
    ex(c0 + 5,  F_SEG3, S1);
    ex(c0 + 8,  F_CNT,  16'h0002);
    ex(c0 + 8,  F_SEG3, S1);
    ex(c0 + 9,  F_SEG3, S2);
    ex(c0 + 12, F_CNT,  16'h0003);
    ex(c0 + 13, F_SEG3, S3);
    ticks(13);

    // load 0099, carry into hundreds
    do_load(16'h0099);
    l = cyc;
    ex(l,     F_CNT,  16'h0099);
    ex(l + 3, F_CNT,  16'h0099);
    ex(l + 4, F_CNT,  16'h0100);
    ex(l + 5, F_SEG1, S1);
    ex(l + 5, F_SEG2, S0);
    ex(l + 5, F_SEG3, S0);
    ticks(5);

    // wrap up at MAX_COUNT, then wrap down from 0000
    do_load(16'h9675);
    l = cyc;
    ex(l,     F_CNT,  16'h9675);
    ex(l,     F_WRAP, 16'h0);
    ex(l + 4, F_CNT,  16'h0000);
    ex(l + 4, F_WRAP, 16'h1);
    ex(l + 5, F_WRAP, 16'h0);
    ex(l + 8, F_CNT,  16'h9675);
    ex(l + 8, F_WRAP, 16'h1);
    ex(l + 9, F_WRAP, 16'h0);
    ex(l + 9, F_SEG0, S9);
    ticks(4);
    bus.up_down = 1'b0;
    ticks(5);

    // down step with borrow across three digits
    do_load(16'h1000);
    n = cyc;
    ex(n,     F_CNT,  16'h1000);
    ex(n + 4, F_CNT,  16'h0999);
    ex(n + 5, F_SEG0, S0);
    ex(n + 5, F_SEG1, S9);
    ticks(5);

    // invalid loads on a pending step: ignored, step suppressed
    bus.up_down = 1'b1;
    bus.clear   = 1'b1;
    tick();
    bus.clear   = 1'b0;
    k = cyc;
    ex(k,      F_CNT, 16'h0000);
    ex(k + 4,  F_CNT, 16'h0000);
    ex(k + 5,  F_CNT, 16'h0001);
    ex(k + 9,  F_CNT, 16'h0001);
    ex(k + 10, F_CNT, 16'h0002);
    // clear+load on a pending step, then en low for 10 clocks
    ex(k + 14, F_CNT, 16'h0000);
    ex(k + 17, F_CNT, 16'h0000);
    ex(k + 18, F_CNT, 16'h0001);
    ex(k + 22, F_CNT, 16'h0001);
    ex(k + 30, F_CNT, 16'h0001);
    ex(k + 31, F_CNT, 16'h0001);
    ex(k + 32, F_CNT, 16'h0002);
    ticks(3);
    do_load(16'h9676);
    ticks(4);
    do_load(16'h00A0);
    ticks(4);
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 16'h1234;
    tick();
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    ticks(6);
    bus.en = 1'b0;
    ticks(10);
    bus.en = 1'b1;
    ticks(2);

    // asynchronous reset mid-count
    do_load(16'h4321);
    m = cyc;
    ex(m,     F_CNT,  16'h4321);
    ex(m + 1, F_SEG0, S4);
    ex(m + 1, F_SEG1, S3);
    ex(m + 1, F_SEG2, S2);
    ex(m + 1, F_SEG3, S1);
    ticks(2);
    #1 rst_n = 1'b0;
    ex(cyc, F_CNT,  16'h0000);
    ex(cyc, F_WRAP, 16'h0);
    ex(cyc, F_SEG0, S0);
    ex(cyc, F_SEG1, S0);
    ex(cyc, F_SEG2, S0);
    ex(cyc, F_SEG3, S0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
